// File: rtl/ternary_result_decoder.sv
// Serial 3's-complement BCT to sign-and-magnitude decoder, one trit per clock, LSB first.
// Define TERN_DEC_BINARY_EN to build the binary magnitude path; otherwise mag_bin is tied to 0.
module ternary_result_decoder #(
   parameter int TRITS = 3,
   parameter int BIN_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*TRITS-1:0] sum_in,
   input  logic               ovf_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sign_out,
   output logic [2*TRITS-1:0] mag_out,
   output logic [BIN_W-1:0]   mag_bin,
   output logic               ovf_out,
   output logic               err_out
);

   localparam int IDX_W = (TRITS > 1) ? $clog2(TRITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } stateType;

   stateType           state;
   stateType           stateNext;
   logic [2*TRITS-1:0] capWord;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic               carryNext;
   logic [1:0]         curTrit;
   logic [1:0]         outTrit;
   logic [2:0]         negSum;
   logic               capNeg;
   logic               lastTrit;
   logic               illegal;
   logic               capture;

   assign in_ready = (state == IDLE);
   assign out_valid = (state == DONE);
   assign capture = in_ready && in_valid;
   assign capNeg = (sum_in[2*TRITS-1 -: 2] == 2'b10);
   assign lastTrit = (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      stateNext = state;
      case (state)
         IDLE:    if (in_valid) stateNext = CONV;
         CONV:    if (lastTrit) stateNext = DONE;
         DONE:    if (out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Negative words are complemented digit by digit (2-d) with an initial +1 rippling up as carry.
   always_comb begin
      curTrit = capWord[{idx, 1'b0} +: 2];
      negSum = 3'd2 - {1'b0, curTrit} + {2'b00, carry};
      outTrit = curTrit;
      carryNext = 1'b0;
      if (sign_out) begin
         if (negSum >= 3'd3) begin
            outTrit = 2'(negSum - 3'd3);
            carryNext = 1'b1;
         end else begin
            outTrit = negSum[1:0];
         end
      end
   end

   always_comb begin
      illegal = 1'b0;
      for (int i = 0; i < TRITS; i++) begin
         if (capWord[2*i +: 2] == 2'b11) illegal = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         capWord <= '0;
         idx <= '0;
         carry <= 1'b0;
         sign_out <= 1'b0;
         mag_out <= '0;
         ovf_out <= 1'b0;
         err_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  capWord <= sum_in;
                  ovf_out <= ovf_in;
                  sign_out <= capNeg;
                  carry <= capNeg;
                  mag_out <= '0;
                  idx <= '0;
                  err_out <= 1'b0;
               end
            end
            CONV: begin
               mag_out[{idx, 1'b0} +: 2] <= outTrit;
               carry <= carryNext;
               idx <= idx + 1'b1;
               if (lastTrit && illegal) begin
                  err_out <= 1'b1;
                  sign_out <= 1'b0;
                  mag_out <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TERN_DEC_BINARY_EN
   logic [BIN_W-1:0] weight;
   logic [BIN_W-1:0] binAcc;

   always_ff @(posedge clk) begin
      if (reset) begin
         weight <= '0;
         binAcc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  weight <= BIN_W'(1);
                  binAcc <= '0;
               end
            end
            CONV: begin
               weight <= weight + {weight[BIN_W-2:0], 1'b0};
               if (lastTrit && illegal) binAcc <= '0;
               else                     binAcc <= binAcc + BIN_W'(outTrit) * weight;
            end
            default: ;
         endcase
      end
   end

   assign mag_bin = binAcc;
`else
   assign mag_bin = '0;
`endif

endmodule

// File: tb/tb_ternary_result_decoder.sv
// Self-checking bench for ternary_result_decoder: arithmetic reference model plus directed vectors.
module tb_ternary_result_decoder;

   localparam int TRITS = 3;
   localparam int BIN_W = 5;
   localparam int W = 2 * TRITS;
`ifdef TERN_DEC_BINARY_EN
   localparam bit BIN_EN = 1'b1;
`else
   localparam bit BIN_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   sum_in;
   logic           ovf_in;
   logic           out_valid;
   logic           out_ready;
   logic           sign_out;
   logic [W-1:0]   mag_out;
   logic [BIN_W-1:0] mag_bin;
   logic           ovf_out;
   logic           err_out;

   typedef struct {
      logic           sign;
      logic [W-1:0]   mag;
      logic [BIN_W-1:0] bin;
      logic           ovf;
      logic           err;
   } resultType;

   int        nCompared = 0;
   int        nMismatched = 0;
   resultType expRes;
   bit        expValid = 1'b0;

   ternary_result_decoder #(.TRITS(TRITS), .BIN_W(BIN_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .sum_in   (sum_in),
      .ovf_in   (ovf_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sign_out (sign_out),
      .mag_out  (mag_out),
      .mag_bin  (mag_bin),
      .ovf_out  (ovf_out),
      .err_out  (err_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: evaluate the word as an integer, take 3^TRITS - N when the top trit is 2, re-encode.
   function automatic resultType model(input logic [W-1:0] w, input logic ovf);
      resultType r;
      int n = 0;
      int p = 1;
      int m;
      int magVal;
      bit bad = 1'b0;
      bit neg;
      for (int i = 0; i < TRITS; i++) begin
         int t = int'(w[2*i +: 2]);
         if (t == 3) bad = 1'b1;
         n += t * p;
         p *= 3;
      end
      neg = (w[W-1 -: 2] == 2'b10);
      magVal = neg ? (p - n) : n;
      m = magVal;
      r.sign = neg;
      r.ovf = ovf;
      r.err = bad;
      r.mag = '0;
      for (int i = 0; i < TRITS; i++) begin
         r.mag[2*i +: 2] = 2'(m % 3);
         m = m / 3;
      end
      r.bin = BIN_EN ? BIN_W'(magVal) : '0;
      if (bad) begin
         r.sign = 1'b0;
         r.mag = '0;
         r.bin = '0;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      check("handshake_exclusive", {31'b0, in_ready & out_valid}, 32'd0);
      if (out_valid) begin
         if (!expValid) begin
            check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
         end else begin
            check("cmp_sign", {31'b0, sign_out}, {31'b0, expRes.sign});
            check("cmp_mag", 32'(mag_out), 32'(expRes.mag));
            check("cmp_bin", 32'(mag_bin), 32'(expRes.bin));
            check("cmp_ovf", {31'b0, ovf_out}, {31'b0, expRes.ovf});
            check("cmp_err", {31'b0, err_out}, {31'b0, expRes.err});
         end
      end
   end

   // Called on a falling edge; returns on the falling edge where out_valid first shows.
   task automatic sendWord(input logic [W-1:0] w, input logic ovf, input bit preReady);
      int budget = 0;
      sum_in = w;
      ovf_in = ovf;
      in_valid = 1'b1;
      out_ready = preReady;
      while (!in_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check("capture_ready", {31'b0, in_ready}, 32'd1);
      expRes = model(w, ovf);
      expValid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      sum_in = ~w;
      ovf_in = ~ovf;
      for (int k = 0; k < TRITS; k++) begin
         check("latency_busy", {30'b0, in_ready, out_valid}, 32'b00);
         @(negedge clk);
      end
      check("latency_done", {30'b0, in_ready, out_valid}, 32'b01);
   endtask

   // Stall in DONE for 'hold' cycles while offering an ignored word, then accept.
   task automatic releaseWord(input int hold, input logic [W-1:0] junk);
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1;
         sum_in = junk;
         @(negedge clk);
         check("hold_stall", {30'b0, in_ready, out_valid}, 32'b01);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("release", {30'b0, in_ready, out_valid}, 32'b10);
      out_ready = 1'b0;
   endtask

   logic [W-1:0] vecs [7] = '{6'b00_00_00, 6'b00_00_10, 6'b10_10_10, 6'b01_01_01,
                              6'b11_00_00, 6'b00_00_11, 6'b10_01_10};

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      sum_in = '0;
      ovf_in = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_outputs", {19'b0, out_valid, sign_out, mag_out, mag_bin, ovf_out, err_out}, 32'd0);

      sendWord(6'b10_00_01, 1'b0, 1'b0);
      check("lit19_sign", {31'b0, sign_out}, 32'd1);
      check("lit19_mag", 32'(mag_out), 32'b00_10_10);
      check("lit19_bin", 32'(mag_bin), BIN_EN ? 32'd8 : 32'd0);
      check("lit19_err", {31'b0, err_out}, 32'd0);
      releaseWord(0, '0);

      sendWord(6'b10_00_00, 1'b0, 1'b0);
      check("lit18_sign", {31'b0, sign_out}, 32'd1);
      check("lit18_mag", 32'(mag_out), 32'b01_00_00);
      check("lit18_bin", 32'(mag_bin), BIN_EN ? 32'd9 : 32'd0);
      releaseWord(0, '0);

      sendWord(6'b01_10_10, 1'b1, 1'b0);
      check("lit17_sign", {31'b0, sign_out}, 32'd0);
      check("lit17_mag", 32'(mag_out), 32'b01_10_10);
      check("lit17_bin", 32'(mag_bin), BIN_EN ? 32'd17 : 32'd0);
      check("lit17_ovf", {31'b0, ovf_out}, 32'd1);
      releaseWord(5, 6'b00_00_01);

      sendWord(6'b00_11_00, 1'b0, 1'b0);
      check("litill_err", {31'b0, err_out}, 32'd1);
      check("litill_mag", 32'(mag_out), 32'd0);
      check("litill_bin", 32'(mag_bin), 32'd0);
      check("litill_sign", {31'b0, sign_out}, 32'd0);
      releaseWord(0, '0);

      for (int i = 0; i < 7; i++) begin
         sendWord(vecs[i], logic'(i % 2), 1'b1);
         releaseWord(0, '0);
      end

      expValid = 1'b0;
      sum_in = 6'b10_00_01;
      ovf_in = 1'b1;
      in_valid = 1'b1;
      check("abort_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("abort_captured", {30'b0, sign_out, ovf_out}, 32'b11);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_in_ready", {31'b0, in_ready}, 32'd1);
      check("abort_outputs", {19'b0, out_valid, sign_out, mag_out, mag_bin, ovf_out, err_out}, 32'd0);
      repeat (TRITS + 2) begin
         @(negedge clk);
         check("abort_no_valid", {31'b0, out_valid}, 32'd0);
      end

      sendWord(6'b00_00_00, 1'b0, 1'b0);
      check("post_abort_sign", {31'b0, sign_out}, 32'd0);
      check("post_abort_mag", 32'(mag_out), 32'd0);
      releaseWord(0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/ternary_result_decoder.md
# ternary_result_decoder

Sequential decoder that converts a 3's-complement, binary-coded-ternary (BCT) adder result back into sign-and-magnitude ternary. It also produces an optional binary magnitude. It sits downstream of the ternary adders and is the inverse of the sign-and-magnitude to 3's-complement input stage. It processes one trit per clock, LSB first, behind a valid/ready handshake on each side.

## Interface
- `TRITS`, default 3: number of trits in the result word; the most significant trit is the sign digit.
- `BIN_W`, default 5: width of the binary magnitude; must hold 3^TRITS − 1 − floor(3^TRITS / 3), which is 17 for TRITS=3.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: `sum_in`/`ovf_in` are valid.
- `in_ready` out 1: block can accept a word; high only in IDLE.
- `sum_in` in 2*TRITS: 3's-complement result in BCT (00=0, 01=1, 10=2, 11=illegal); bits [1:0] hold the LSB trit.
- `ovf_in` in 1: adder overflow flag, captured with `sum_in`.
- `out_valid` out 1: outputs below are valid and held stable.
- `out_ready` in 1: consumer accepts the outputs.
- `sign_out` out 1: 1 = negative.
- `mag_out` out 2*TRITS: magnitude in BCT.
- `mag_bin` out BIN_W: magnitude in unsigned binary.
- `ovf_out` out 1: captured `ovf_in`.
- `err_out` out 1: an illegal trit code (11) was present in the captured word.

## Operation
- Sign rule: the value is negative if and only if the captured MS trit equals 2 (10).
  - Negative: magnitude = 3^TRITS − N.
  - Otherwise: magnitude = N.
- States and transitions:
  - **IDLE**: `in_ready`=1. On `in_valid`: capture `sum_in` and `ovf_in`, set `sign_out`, clear the accumulators, set index=0, set carry=1 if negative else 0, go to CONV.
  - **CONV**: one trit per edge, starting at index 0.
    - Negative: digit d' = (2−d)+carry, reduced mod 3; carry = (d'' ≥ 3), where d'' is the unreduced sum.
    - Positive: d' = d.
    - Write d' into `mag_out[2i+1:2i]` and add d'·3^i to `mag_bin`, using a running weight register of 1, 3, 9, …
    - After index TRITS−1 is processed, go to DONE.
  - **DONE**: `out_valid`=1 and all outputs are held. When `out_ready`=1, go to IDLE.
- `in_ready` and `out_valid` are never both high in the same cycle.
- Illegal code: if any captured trit is 11, the result is forced at the DONE transition to `err_out`=1, `sign_out`=0, `mag_out`=0, `mag_bin`=0. Conversion still takes the full TRITS cycles.
- `err_out` and `ovf_out` are registered outputs held through DONE; they are not cleared until the next capture.
- Reset:
  - Any state goes to IDLE.
  - All outputs go to 0, except `in_ready`, which is 1 in the cycle after reset.
  - Reset asserted mid-CONV discards the word; no `out_valid` follows.

## Timing
- Capture edge E0 is the edge where `in_valid`&&`in_ready`.
- CONV edges are E1..E_TRITS; `out_valid` rises after E_TRITS (3 cycles after E0 for the default).
- Release:
  - `out_valid` falls on the edge where `out_ready`=1.
  - `in_ready` rises on that same edge.
  - The next capture is possible at the following edge.
  - Minimum period between words is TRITS+2 cycles.
- If `out_ready` is already high when DONE is entered, DONE lasts exactly one cycle.
- `in_valid` while busy is ignored; the upstream block must hold it until `in_ready`.
- `sum_in` is sampled only at E0; changes during CONV have no effect.

## Configuration
- `TERN_DEC_BINARY_EN` defined: the weight register and binary accumulator are built, and `mag_bin` is as specified.
- Not defined: neither is built, `mag_bin` is tied to 0, and all other behaviour and timing are unchanged.

## Test plan
- Negative with carry chain: `sum_in`=6'b10_00_01 (19) -> after 3 cycles `sign_out`=1, `mag_out`=6'b00_10_10, `mag_bin`=8, `err_out`=0.
- Negative, maximum magnitude: `sum_in`=6'b10_00_00 (18) -> `sign_out`=1, `mag_out`=6'b01_00_00, `mag_bin`=9.
- Positive maximum: `sum_in`=6'b01_10_10 (17) with `ovf_in`=1 -> `sign_out`=0, `mag_out`=6'b01_10_10, `mag_bin`=17, `ovf_out`=1.
- Illegal code: `sum_in`=6'b00_11_00 -> `err_out`=1, `mag_out`=0, `mag_bin`=0, `sign_out`=0.
- Handshake backpressure:
  - Hold `out_ready`=0 for 5 cycles: outputs stay stable, `in_ready`=0, and a new `in_valid` is ignored.
  - Then assert `out_ready`: `in_ready` is 1 on the next cycle.
- Reset mid-CONV: pulse `reset` at E2 -> IDLE, all outputs 0, `in_ready`=1, no `out_valid`. A following word of 0 decodes to `sign_out`=0, `mag_out`=0.
